// File: rtl/cpu_multicycle_pkg.sv
// Shared definitions for the parametrised multi-cycle core: opcodes, FSM states,
// ALU selects and instruction field positions.
package cpu_multicycle_pkg;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_LI    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_BEQ   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_LUI   = 4'h9;
  localparam logic [3:0] OP_ORI   = 4'hA;

  typedef enum logic [2:0] {
    S_FETCH, S_IR, S_DEC, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_MUL, ALU_PASS_B, ALU_OR, ALU_LUI
  } alu_op_t;

  // MSB positions of the register fields; each field is RAW bits wide
  function automatic int fa_msb(int w);
    return w - 5;
  endfunction

  function automatic int fb_msb(int w, int raw);
    return w - 5 - raw;
  endfunction

  function automatic int fc_msb(int w, int raw);
    return w - 5 - 2 * raw;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational W-bit ALU: add, low-half multiply, pass, or, and byte-shifted immediate.
module cpu_alu
  import cpu_multicycle_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_op_t'(op))
      ALU_ADD:    y = a + b;
      ALU_MUL:    y = a * b;
      ALU_PASS_B: y = b;
      ALU_OR:     y = a | b;
      ALU_LUI:    y = b << 8;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle_param.sv
// Parametrised multi-cycle core with sync instruction ROM and req/ack data port.
// Optional CPU_PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
module cpu_multicycle_param
  import cpu_multicycle_pkg::*;
#(
  parameter int          W          = 24,
  parameter int          RAW        = 6,
  parameter int          IAW        = 10,
  parameter int          DAW        = 14,
  parameter int unsigned PROT_LIMIT = 'h3000
) (
  input  logic           clk,
  input  logic           rst,
  output logic [IAW-1:0] imem_addr,
  input  logic [W-1:0]   imem_rdata,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [W-1:0]   dmem_wdata,
  input  logic [W-1:0]   dmem_rdata,
  input  logic           dmem_ack,
  output logic           halt,
  output logic           store_fault,
  output logic [IAW-1:0] dbg_pc
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    instret_cnt
`endif
);

  localparam int NREG = 2 ** RAW;
  localparam int FA   = fa_msb(W);
  localparam int FB   = fb_msb(W, RAW);
  localparam int FC   = fc_msb(W, RAW);

  state_t                 state;
  logic [IAW-1:0]         pc;
  logic [W-1:0]           ir, a_q, b_q, alu_out, mdr;
  logic [NREG-1:0][W-1:0] rf;

  logic [3:0]     op;
  logic [RAW-1:0] f_a, f_b, f_c;
  logic [7:0]     imm8;
  logic [W-1:0]   imm_s, imm_z, alu_b, alu_y;
  alu_op_t        alu_sel;
  logic           op_wb, blocked;

  assign op    = ir[W-1 -: 4];
  assign f_a   = ir[FA -: RAW];
  assign f_b   = ir[FB -: RAW];
  assign f_c   = ir[FC -: RAW];
  assign imm8  = ir[7:0];
  assign imm_s = W'($signed(imm8));
  assign imm_z = W'(imm8);
  assign op_wb = op inside {OP_ADD, OP_MUL, OP_LI, OP_LUI, OP_ORI};

  always_comb begin
    alu_sel = ALU_ADD;
    alu_b   = b_q;
    case (op)
      OP_MUL:            alu_sel = ALU_MUL;
      OP_LI:             begin alu_sel = ALU_PASS_B; alu_b = imm_s; end
      OP_LOAD, OP_STORE: alu_b = imm_s;
      OP_LUI:            begin alu_sel = ALU_LUI; alu_b = imm_z; end
      OP_ORI:            begin alu_sel = ALU_OR;  alu_b = imm_z; end
      default:           ;
    endcase
  end

  cpu_alu #(.W(W)) u_alu (.a(a_q), .b(alu_b), .op(alu_sel), .y(alu_y));

  // protection is decided in S_EXEC so a blocked store never raises dmem_req
  assign blocked = 32'(alu_y[DAW-1:0]) < PROT_LIMIT;

  assign imem_addr  = pc;
  assign dbg_pc     = pc;
  assign dmem_addr  = alu_out[DAW-1:0];
  assign dmem_wdata = b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_out     <= '0;
      mdr         <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      halt        <= 1'b0;
      store_fault <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_IR;
        S_IR: begin
          ir    <= imem_rdata;
          pc    <= pc + IAW'(1);
          state <= S_DEC;
        end
        S_DEC: begin
          a_q   <= rf[f_b];
          b_q   <= (op == OP_STORE || op == OP_BEQ) ? rf[f_a] : rf[f_c];
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_out <= alu_y;
          state   <= S_FETCH;
          case (op)
            OP_HALT: begin state <= S_HALT; halt <= 1'b1; end
            OP_BEQ:  if (a_q == b_q) pc <= pc + IAW'($signed(imm8));
            OP_JMP:  pc <= ir[IAW-1:0];
            OP_LOAD, OP_STORE: begin
              state   <= S_MEM;
              dmem_we <= (op == OP_STORE);
              if (op == OP_STORE && blocked) store_fault <= 1'b1;
              else                           dmem_req    <= 1'b1;
            end
            default: if (op_wb) state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (store_fault) begin
            store_fault <= 1'b0;
            state       <= S_FETCH;
          end else if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) mdr <= dmem_rdata;
            state <= dmem_we ? S_FETCH : S_WB;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  ;
        default: state <= S_FETCH;
      endcase
    end
  end

  // R0 is never written, so it reads as zero from reset onward
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rf <= '0;
    else if (state == S_WB && f_a != '0)
      rf[f_a] <= (op == OP_LOAD) ? mdr : alu_out;
  end

`ifdef CPU_PERF_CNT_EN
  logic retire;

  always_comb begin
    case (state)
      S_EXEC:  retire = !op_wb && op != OP_LOAD && op != OP_STORE && op != OP_HALT;
      S_MEM:   retire = dmem_we && (store_fault || dmem_ack);
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (state != S_HALT) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
